load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the unified memory's data port (en/rw/addr/wdata/rdata).
- Accepts byte, halfword and word loads/stores from the execute stage using a valid/ready request and a one-cycle response pulse.
- Translates each request into word-addressed memory accesses. Sub-word stores use read-modify-write because memory writes are word-only.
- Detects misaligned and out-of-range accesses and never touches memory for them.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in memory; word index must be < MEM_WORDS.
- IDX_W, 10: width of the word index driven to memory (log2 MEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal size.
- mem_en  out  1  drives memory Op2En.
- mem_rw  out  1  drives memory Op2RW (0 = read, 1 = write).
- mem_addr  out  32  word index (req_addr >> 2), zero-extended.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, any state): state = IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; mem_en = 0; mem_rw = 0; mem_addr = 0; mem_wdata = 0; resp_rdata = 0.
- Reset mid-operation: any in-flight access is abandoned and no response is issued.
- All mem_* outputs are registered, so they change only on rising clk. mem_rw must never change while mem_en = 1 within a cycle, because memory writes are level-sensitive.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid = 1 at a rising edge.
  - Latch we, size, signed, byte offset addr[1:0], wdata.
  - Error check, in priority order: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; (addr >> 2) >= MEM_WORDS.
  - Error → RESP with err = 1 and mem_en held at 0.
  - Load → RD, with mem_en = 1, mem_rw = 0.
  - Word store → WR, with mem_en = 1, mem_rw = 1, mem_wdata = req_wdata.
  - Byte/half store → RMW_RD, with mem_en = 1, mem_rw = 0.
- RD:
  - Capture mem_rdata at the edge.
  - Lane select is little-endian: byte lane = offset, half lane = offset[1].
  - Extend per size/signed into resp_rdata.
  - Set mem_en = 0 → RESP.
- RMW_RD:
  - Capture mem_rdata and merge the low byte/half of wdata into the selected lane; other lanes are unchanged.
  - Register the merged word into mem_wdata with mem_rw = 1 and mem_en = 1 → WR.
- WR: memory writes during this cycle. Set mem_en = 0, mem_rw = 0 → RESP.
- RESP: resp_valid = 1 for exactly one cycle, req_ready = 0 → IDLE. No backpressure on the response.
- req_ready = 1 only in IDLE, so at most one request is outstanding.
- Latency from acceptance edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Back-to-back requests: a new request is accepted in the IDLE cycle after RESP. Throughput is therefore one request per latency + 1 cycles.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Word load: preload mem[5] = 0x8899AABB; req addr 0x14, size 10 → resp_valid 2 cycles after accept, rdata 0x8899AABB, err 0; exactly one cycle of mem_en = 1, rw = 0, mem_addr = 5.
- Signed/unsigned byte: mem[2] = 0x12F4_5680; load byte at 0x0A, signed → 0xFFFFFFF4; unsigned → 0x000000F4. Half at 0x08, signed → 0x00005680.
- Sub-word store: mem[3] = 0xAABBCCDD; store byte 0x11 at 0x0D → mem[3] = 0xAABB11DD after RESP; trace is 1 read cycle then 1 write cycle; a subsequent word load returns 0xAABB11DD.
- Errors: word at 0x06, half at 0x03, size 11, word at 0x1000 (index 1024) → each gives resp_err = 1 one cycle after accept, rdata 0; mem_en stays 0 throughout.
- Back-to-back: hold req_valid high with 3 queued requests → req_ready low between accepts; responses arrive in order, with no overlap of mem_en between requests.
- Async reset: assert rst_n = 0 during the RMW_RD cycle of a byte store → mem_en drops immediately; the target word is unchanged; no resp_valid; the unit accepts a new request the first cycle after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-wide memory accesses,
// using read-modify-write for sub-word stores and rejecting bad accesses up front.
module load_store_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  size_r, size_s;
  logic        sgn_r, sgn_s;
  logic [1:0]  off_r, off_s;
  logic [31:0] wdata_r, wdata_s;
  logic        err_s;
  logic        req_ready_s, resp_valid_s, resp_err_s, mem_en_s, mem_rw_s;
  logic [31:0] resp_rdata_s, mem_addr_s, mem_wdata_s;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the low bits of the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          2'b11:   r[31:24] = wd[7:0];
          default: r = word;
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Request error classification in priority order.
  always_comb begin
    if (req_size == 2'b11)                                 err_s = 1'b1;
    else if (req_size == 2'b01 && req_addr[0])             err_s = 1'b1;
    else if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  err_s = 1'b1;
    else if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))    err_s = 1'b1;
    else                                                   err_s = 1'b0;
  end

  // Next-state and next-output logic; every output is the registered copy of a value computed here.
  always_comb begin
    state_s      = state_r;
    size_s       = size_r;
    sgn_s        = sgn_r;
    off_s        = off_r;
    wdata_s      = wdata_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = resp_err;
    resp_rdata_s = resp_rdata;
    mem_en_s     = mem_en;
    mem_rw_s     = mem_rw;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          size_s       = req_size;
          sgn_s        = req_signed;
          off_s        = req_addr[1:0];
          wdata_s      = req_wdata;
          resp_rdata_s = 32'h0000_0000;
          if (err_s) begin
            state_s      = RESP;
            resp_err_s   = 1'b1;
            resp_valid_s = 1'b1;
          end else begin
            resp_err_s = 1'b0;
            mem_en_s   = 1'b1;
            mem_addr_s = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
            if (!req_we) begin
              state_s  = RD;
              mem_rw_s = 1'b0;
            end else if (req_size == 2'b10) begin
              state_s     = WR;
              mem_rw_s    = 1'b1;
              mem_wdata_s = req_wdata;
            end else begin
              state_s  = RMW_RD;
              mem_rw_s = 1'b0;
            end
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      RD: begin
        resp_rdata_s = load_extend(mem_rdata, size_r, off_r, sgn_r);
        mem_en_s     = 1'b0;
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RMW_RD: begin
        mem_wdata_s = merge_lane(mem_rdata, wdata_r, size_r, off_r);
        mem_rw_s    = 1'b1;
        mem_en_s    = 1'b1;
        state_s     = WR;
      end
      WR: begin
        mem_en_s     = 1'b0;
        mem_rw_s     = 1'b0;
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        state_s      = IDLE;
        req_ready_s  = 1'b1;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0000_0000;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
        mem_en_s    = 1'b0;
        mem_rw_s    = 1'b0;
      end
    endcase
  end

  // State, latched request fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      size_r     <= 2'b00;
      sgn_r      <= 1'b0;
      off_r      <= 2'b00;
      wdata_r    <= 32'h0000_0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      size_r     <= size_s;
      sgn_r      <= sgn_s;
      off_r      <= off_s;
      wdata_r    <= wdata_s;
      req_ready  <= req_ready_s;
      resp_valid <= resp_valid_s;
      resp_err   <= resp_err_s;
      resp_rdata <= resp_rdata_s;
      mem_en     <= mem_en_s;
      mem_rw     <= mem_rw_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory on the data port.
module tb_load_store_unit;

  logic        clk, rst_n, req_valid, req_ready, req_we, req_signed;
  logic        resp_valid, resp_err, mem_en, mem_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:1023];
  logic [31:0] last_addr;
  int n_checks = 0;
  int n_fail = 0;
  int rd_cyc = 0, wr_cyc = 0, resp_cnt = 0, overlap_cnt = 0;

  load_store_unit #(.MEM_WORDS(1024), .IDX_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_en && mem_rw) mem[mem_addr[9:0]] = mem_wdata;

  // Trace monitor: memory cycles, response pulses, and memory activity outside an access.
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_rw) wr_cyc++; else rd_cyc++;
      last_addr = mem_addr;
    end
    if (resp_valid) resp_cnt++;
    if (mem_en && (req_ready || resp_valid)) overlap_cnt++;
  end

  task automatic clear_counters();
    rd_cyc = 0; wr_cyc = 0; resp_cnt = 0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk); #1;
    clear_counters();
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 99; rd = 32'hDEAD_DEAD; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; rd = resp_rdata; err = resp_err; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({req_ready, resp_valid, resp_err, mem_en, mem_rw} !== 5'b10000) begin n_fail++; $display("FAIL reset_flags: got %b want 10000", {req_ready, resp_valid, resp_err, mem_en, mem_rw}); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    logic [31:0] rd; logic err; int lat;
    mem[5] = 32'h8899_AABB;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, err, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wload_latency: got %0d want 2", lat); end
    n_checks++; if (rd !== 32'h8899_AABB) begin n_fail++; $display("FAIL wload_rdata: got %h want 8899aabb", rd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wload_err: got %b want 0", err); end
    n_checks++; if (rd_cyc !== 1 || wr_cyc !== 0) begin n_fail++; $display("FAIL wload_trace: got rd=%0d wr=%0d want rd=1 wr=0", rd_cyc, wr_cyc); end
    n_checks++; if (last_addr !== 32'd5) begin n_fail++; $display("FAIL wload_addr: got %h want 5", last_addr); end
  endtask

  task automatic test_subword_load();
    logic [31:0] rd; logic err; int lat;
    logic [31:0] ta [0:6];
    logic [1:0]  ts [0:6];
    logic        tg [0:6];
    logic [31:0] te [0:6];
    ta = '{32'h0A, 32'h0A, 32'h08, 32'h08, 32'h0A, 32'h0B, 32'h22};
    ts = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    tg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    te = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'h0000_5680, 32'hFFFF_FF80,
           32'h0000_12F4, 32'h0000_0012, 32'hFFFF_8001};
    mem[2] = 32'h12F4_5680;
    mem[8] = 32'h8001_7FFF;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, ts[i], tg[i], ta[i], 32'h0, rd, err, lat);
      n_checks++; if (rd !== te[i] || err !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL subload_%0d: got rdata=%h err=%b lat=%0d want rdata=%h err=0 lat=2", i, rd, err, lat, te[i]); end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic err; int lat;
    mem[3] = 32'hAABB_CCDD;
    issue(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0011, rd, err, lat);
    n_checks++; if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL bstore_resp: got lat=%0d err=%b rdata=%h want 3 0 0", lat, err, rd); end
    n_checks++; if (rd_cyc !== 1 || wr_cyc !== 1) begin n_fail++; $display("FAIL bstore_trace: got rd=%0d wr=%0d want 1 1", rd_cyc, wr_cyc); end
    n_checks++; if (mem[3] !== 32'hAABB_11DD) begin n_fail++; $display("FAIL bstore_mem: got %h want aabb11dd", mem[3]); end
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, rd, err, lat);
    n_checks++; if (rd !== 32'hAABB_11DD) begin n_fail++; $display("FAIL bstore_readback: got %h want aabb11dd", rd); end
    issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234_BEEF, rd, err, lat);
    n_checks++; if (lat !== 3 || mem[3] !== 32'hBEEF_11DD) begin n_fail++; $display("FAIL hstore: got lat=%0d mem=%h want 3 beef11dd", lat, mem[3]); end
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, rd, err, lat);
    n_checks++; if (lat !== 2 || mem[4] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wstore: got lat=%0d mem=%h want 2 cafef00d", lat, mem[4]); end
    n_checks++; if (rd_cyc !== 0 || wr_cyc !== 1) begin n_fail++; $display("FAIL wstore_trace: got rd=%0d wr=%0d want 0 1", rd_cyc, wr_cyc); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    logic        tw [0:4];
    logic [1:0]  ts [0:4];
    logic [31:0] ta [0:4];
    tw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    ta = '{32'h06, 32'h03, 32'h00, 32'h1000, 32'h1003};
    for (int i = 0; i < 5; i++) begin
      issue(tw[i], ts[i], 1'b1, ta[i], 32'hFFFF_FFFF, rd, err, lat);
      n_checks++; if (err !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_%0d: got err=%b lat=%0d rdata=%h want 1 1 0", i, err, lat, rd); end
      n_checks++; if (rd_cyc + wr_cyc !== 0) begin n_fail++; $display("FAIL err_%0d_mem_en: got %0d cycles want 0", i, rd_cyc + wr_cyc); end
    end
    mem[1023] = 32'h0BAD_F00D;
    issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, err, lat);
    n_checks++; if (err !== 1'b0 || rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL last_word: got err=%b rdata=%h want 0 0badf00d", err, rd); end
  endtask

  task automatic test_back_to_back();
    logic        tw [0:2];
    logic [1:0]  ts [0:2];
    logic [31:0] ta [0:2];
    logic [31:0] td [0:2];
    logic [31:0] te [0:2];
    logic [31:0] got [0:2];
    int nresp = 0, idx = 0, accepts = 0, stalls = 0;
    logic was_ready;
    tw = '{1'b0, 1'b0, 1'b1};
    ts = '{2'b10, 2'b00, 2'b10};
    ta = '{32'h14, 32'h0D, 32'h18};
    td = '{32'h0, 32'h0, 32'h0102_0304};
    te = '{32'h8899_AABB, 32'h0000_0011, 32'h0000_0000};
    got = '{32'hDEAD_DEAD, 32'hDEAD_DEAD, 32'hDEAD_DEAD};
    @(posedge clk); #1;
    clear_counters();
    overlap_cnt = 0;
    req_we = tw[0]; req_size = ts[0]; req_signed = 1'b0; req_addr = ta[0]; req_wdata = td[0];
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin got[nresp] = resp_rdata; nresp++; end
      was_ready = req_ready;
      if (req_valid && !req_ready) stalls++;
      @(posedge clk); #1;
      if (was_ready && req_valid) begin
        accepts++;
        idx++;
        if (idx < 3) begin
          req_we = tw[idx]; req_size = ts[idx]; req_addr = ta[idx]; req_wdata = td[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (got[i] !== te[i]) begin n_fail++; $display("FAIL b2b_resp_%0d: got %h want %h", i, got[i], te[i]); end
    end
    n_checks++; if (accepts !== 3 || stalls !== 4) begin n_fail++; $display("FAIL b2b_handshake: got accepts=%0d stalls=%0d want 3 4", accepts, stalls); end
    n_checks++; if (overlap_cnt !== 0 || rd_cyc !== 2 || wr_cyc !== 1) begin n_fail++; $display("FAIL b2b_mem_trace: got overlap=%0d rd=%0d wr=%0d want 0 2 1", overlap_cnt, rd_cyc, wr_cyc); end
    n_checks++; if (mem[6] !== 32'h0102_0304) begin n_fail++; $display("FAIL b2b_store: got %h want 01020304", mem[6]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd; logic err; int lat;
    mem[7] = 32'h5566_7788;
    @(negedge clk); #1;
    clear_counters();
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h1D; req_wdata = 32'h99;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if ({mem_en, mem_rw} !== 2'b10) begin n_fail++; $display("FAIL arst_in_rmw: got en,rw=%b want 10", {mem_en, mem_rw}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_immediate: got en=%b ready=%b want 0 1", mem_en, req_ready); end
    repeat (3) @(negedge clk);
    n_checks++; if (resp_cnt !== 0 || wr_cyc !== 0 || mem[7] !== 32'h5566_7788) begin n_fail++; $display("FAIL arst_abandon: got resp=%0d wr=%0d mem=%h want 0 0 55667788", resp_cnt, wr_cyc, mem[7]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, rd, err, lat);
    n_checks++; if (lat !== 2 || rd !== 32'h5566_7788 || err !== 1'b0) begin n_fail++; $display("FAIL arst_recover: got lat=%0d rdata=%h err=%b want 2 55667788 0", lat, rd, err); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word_load();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
